// File: rtl/hbm_bringup_seq.sv
// Power-on and recovery reset sequencer for the HBM2e AXI subsystem.
// Releases IOPLL, HBM, NoC and AXI resets in order, retries failed bring-ups and latches thermal shutdown.
module hbm_bringup_seq #(
  parameter int unsigned RESET_HOLD_CYC  = 16,
  parameter int unsigned PLL_TIMEOUT_CYC = 100000,
  parameter int unsigned CAL_TIMEOUT_CYC = 2000000,
  parameter int unsigned SETTLE_CYC      = 32,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter logic [2:0]  TEMP_WARN       = 3'd5
) (
  input  logic       clk100_in_clk,
  input  logic       seq_reset_in_reset,
  input  logic       restart_req,
  input  logic       iopll_locked_export,
  input  logic       hbm_local_cal_success_local_cal_success,
  input  logic       hbm_local_cal_fail_local_cal_fail,
  input  logic       hbm_fp_0_cattrip_i_conduit,
  input  logic [2:0] hbm_fp_0_temp_i_conduit,
  output logic       iopll_reset_reset,
  output logic       hbm_reset_in_reset,
  output logic       noc_reset_in_reset,
  output logic       axi_reset_in_reset,
  output logic       seq_ready,
  output logic       seq_fail,
  output logic       thermal_trip,
  output logic       temp_warn,
  output logic [2:0] seq_state,
  output logic [3:0] retry_count
);

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_PLL_WAIT   = 3'd1,
    ST_CAL_WAIT   = 3'd2,
    ST_NOC_SETTLE = 3'd3,
    ST_RUN        = 3'd4,
    ST_RETRY      = 3'd5,
    ST_FAIL       = 3'd6,
    ST_THERMAL    = 3'd7
  } state_e;

  localparam logic [23:0] HOLD_LAST   = 24'(RESET_HOLD_CYC - 1);
  localparam logic [23:0] PLL_LAST    = 24'(PLL_TIMEOUT_CYC - 1);
  localparam logic [23:0] CAL_LAST    = 24'(CAL_TIMEOUT_CYC - 1);
  localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYC - 1);
  localparam logic [3:0]  MAX_R       = 4'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic [23:0] tmr_q, tmr_d;
  logic [3:0]  retry_q, retry_d;
  logic [3:0]  rst_q, rst_d;
  logic        ready_q, ready_d;
  logic        fail_q, fail_d;
  logic        trip_q, trip_d;
  logic        warn_q, warn_d;

  logic [6:0]  async_in;
  logic [6:0]  meta_q;
  logic [6:0]  sync_q;
  logic        lock_s, cal_ok_s, cal_fail_s, cattrip_s;
  logic [2:0]  temp_s;
  logic        restart_take;
  logic        entering;

  assign async_in = {hbm_fp_0_temp_i_conduit,
                     hbm_fp_0_cattrip_i_conduit,
                     hbm_local_cal_fail_local_cal_fail,
                     hbm_local_cal_success_local_cal_success,
                     iopll_locked_export};

  assign lock_s     = sync_q[0];
  assign cal_ok_s   = sync_q[1];
  assign cal_fail_s = sync_q[2];
  assign cattrip_s  = sync_q[3];
  assign temp_s     = sync_q[6:4];

  always_ff @(posedge clk100_in_clk) begin
    if (seq_reset_in_reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk100_in_clk) begin
    if (seq_reset_in_reset) begin
      state_q <= ST_RESET_HOLD;
      tmr_q   <= '0;
      retry_q <= '0;
      rst_q   <= 4'hF;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
      trip_q  <= 1'b0;
      warn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      retry_q <= retry_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      fail_q  <= fail_d;
      trip_q  <= trip_d;
      warn_q  <= warn_d;
    end
  end

  // Normal transitions first, then restart, then cattrip override them in rising priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET_HOLD: if (tmr_q == HOLD_LAST) state_d = ST_PLL_WAIT;
      ST_PLL_WAIT: begin
        if (lock_s)                  state_d = ST_CAL_WAIT;
        else if (tmr_q == PLL_LAST)  state_d = ST_RETRY;
      end
      ST_CAL_WAIT: begin
        if (cal_fail_s)              state_d = ST_RETRY;
        else if (cal_ok_s)           state_d = ST_NOC_SETTLE;
        else if (tmr_q == CAL_LAST)  state_d = ST_RETRY;
        else if (!lock_s)            state_d = ST_RETRY;
      end
      ST_NOC_SETTLE: begin
        if (!lock_s)                   state_d = ST_RETRY;
        else if (tmr_q == SETTLE_LAST) state_d = ST_RUN;
      end
      ST_RUN:   if (!lock_s || cal_fail_s) state_d = ST_RETRY;
      ST_RETRY: state_d = (retry_q == MAX_R) ? ST_FAIL : ST_RESET_HOLD;
      ST_FAIL:    state_d = ST_FAIL;
      ST_THERMAL: state_d = ST_THERMAL;
      default:    state_d = ST_RESET_HOLD;
    endcase

    restart_take = restart_req && (state_q != ST_THERMAL) && !cattrip_s;
    if (restart_take) state_d = ST_RESET_HOLD;
    if (cattrip_s)    state_d = ST_THERMAL;

    // A restart re-enters RESET_HOLD even from RESET_HOLD, so it must also restart the timer.
    entering = (state_d != state_q) || restart_take;
    if (entering)             tmr_d = '0;
    else if (tmr_q == '1)     tmr_d = tmr_q;
    else                      tmr_d = tmr_q + 24'd1;

    retry_d = retry_q;
    if (restart_take)
      retry_d = '0;
    else if (entering && state_d == ST_RUN)
      retry_d = '0;
    else if (entering && state_d == ST_RETRY && retry_q != 4'hF)
      retry_d = retry_q + 4'd1;

    case (state_d)
      ST_PLL_WAIT:   rst_d = 4'b0111;
      ST_CAL_WAIT:   rst_d = 4'b0011;
      ST_NOC_SETTLE: rst_d = 4'b0001;
      ST_RUN:        rst_d = 4'b0000;
      default:       rst_d = 4'b1111;
    endcase

    ready_d = (state_d == ST_RUN);
    fail_d  = (state_d == ST_FAIL);
    trip_d  = trip_q || (state_d == ST_THERMAL);
    warn_d  = (temp_s >= TEMP_WARN);
  end

  assign iopll_reset_reset  = rst_q[3];
  assign hbm_reset_in_reset = rst_q[2];
  assign noc_reset_in_reset = rst_q[1];
  assign axi_reset_in_reset = rst_q[0];
  assign seq_ready          = ready_q;
  assign seq_fail           = fail_q;
  assign thermal_trip       = trip_q;
  assign temp_warn          = warn_q;
  assign seq_state          = state_q;
  assign retry_count        = retry_q;

endmodule

// File: tb/tb_hbm_bringup_seq.sv
// Scoreboard bench for hbm_bringup_seq: expectations are queued per absolute cycle and
// compared on the falling edge once that cycle's rising edge has happened.
module tb_hbm_bringup_seq;

  localparam int F_RST = 0, F_READY = 1, F_FAIL = 2, F_TRIP = 3, F_WARN = 4, F_STATE = 5, F_RETRY = 6;
  localparam int S_LOCK = 0, S_CALOK = 1, S_CALFAIL = 2, S_CATTRIP = 3, S_TEMP = 4, S_RESTART = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restartReq = 1'b0;
  logic       lockIn = 1'b0;
  logic       calOk = 1'b0;
  logic       calFail = 1'b0;
  logic       catTrip = 1'b0;
  logic [2:0] tempIn = 3'd0;

  logic       iopllRst, hbmRst, nocRst, axiRst;
  logic       seqReady, seqFail, thermalTrip, tempWarn;
  logic [2:0] seqState;
  logic [3:0] retryCount;

  int cycleCnt = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string tag;
  } scoreEntry_t;

  scoreEntry_t expQ[$];

  hbm_bringup_seq #(
    .RESET_HOLD_CYC (16),
    .PLL_TIMEOUT_CYC(1000),
    .CAL_TIMEOUT_CYC(5000),
    .SETTLE_CYC     (32),
    .MAX_RETRIES    (3),
    .TEMP_WARN      (3'd5)
  ) dut (
    .clk100_in_clk                          (clk),
    .seq_reset_in_reset                     (rst),
    .restart_req                            (restartReq),
    .iopll_locked_export                    (lockIn),
    .hbm_local_cal_success_local_cal_success(calOk),
    .hbm_local_cal_fail_local_cal_fail      (calFail),
    .hbm_fp_0_cattrip_i_conduit             (catTrip),
    .hbm_fp_0_temp_i_conduit                (tempIn),
    .iopll_reset_reset                      (iopllRst),
    .hbm_reset_in_reset                     (hbmRst),
    .noc_reset_in_reset                     (nocRst),
    .axi_reset_in_reset                     (axiRst),
    .seq_ready                              (seqReady),
    .seq_fail                               (seqFail),
    .thermal_trip                           (thermalTrip),
    .temp_warn                              (tempWarn),
    .seq_state                              (seqState),
    .retry_count                            (retryCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic logic [31:0] getField(input int sel);
    case (sel)
      F_RST:   return {28'd0, iopllRst, hbmRst, nocRst, axiRst};
      F_READY: return {31'd0, seqReady};
      F_FAIL:  return {31'd0, seqFail};
      F_TRIP:  return {31'd0, thermalTrip};
      F_WARN:  return {31'd0, tempWarn};
      F_STATE: return {29'd0, seqState};
      default: return {28'd0, retryCount};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, observed, expected, cycleCnt);
    end
  endtask

  task automatic pushExpect(input int cyc, input int sel, input int val, input string tag);
    scoreEntry_t e;
    int i = 0;
    e.cyc = cyc;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    while (i < expQ.size() && expQ[i].cyc <= cyc) i++;
    expQ.insert(i, e);
  endtask

  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cycleCnt) begin
      scoreEntry_t e;
      e = expQ.pop_front();
      if (e.cyc < cycleCnt) checkOutput({e.tag, "_stale"}, 32'(cycleCnt), 32'(e.cyc));
      else                  checkOutput(e.tag, getField(e.sel), 32'(e.val));
    end
  end

  task automatic applyStimulus(input int cyc, input int sig, input int val);
    while (cycleCnt < cyc) @(negedge clk);
    case (sig)
      S_LOCK:    lockIn     = val[0];
      S_CALOK:   calOk      = val[0];
      S_CALFAIL: calFail    = val[0];
      S_CATTRIP: catTrip    = val[0];
      S_TEMP:    tempIn     = val[2:0];
      default:   restartReq = val[0];
    endcase
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (expQ.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() > 0) begin
      checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
      expQ.delete();
    end
  endtask

  task automatic expectResetValues(input int cyc, input string p);
    pushExpect(cyc, F_RST,   15, {p, "_resets"});
    pushExpect(cyc, F_READY, 0,  {p, "_ready"});
    pushExpect(cyc, F_FAIL,  0,  {p, "_fail"});
    pushExpect(cyc, F_TRIP,  0,  {p, "_trip"});
    pushExpect(cyc, F_WARN,  0,  {p, "_warn"});
    pushExpect(cyc, F_STATE, 0,  {p, "_state"});
    pushExpect(cyc, F_RETRY, 0,  {p, "_retry"});
  endtask

  // Cycle numbers below count rising edges after reset release (edge 1 is the first free edge).
  task automatic resetDut(input string p, output int base);
    int c;
    @(negedge clk);
    rst = 1'b1;
    c = cycleCnt;
    expectResetValues(c + 1, {p, "_rst1"});
    expectResetValues(c + 3, {p, "_rst3"});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = cycleCnt;
    drain(10);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed %0d expected 0 pending", expQ.size());
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int b;

    // Nominal bring-up: lock at 50, cal success at 300
    resetDut("nom", b);
    pushExpect(b + 15,  F_RST,   4'b1111, "nom_hold");
    pushExpect(b + 16,  F_RST,   4'b0111, "nom_iopll_rel");
    pushExpect(b + 16,  F_STATE, 1,       "nom_pll_wait");
    pushExpect(b + 52,  F_RST,   4'b0111, "nom_pre_hbm");
    pushExpect(b + 53,  F_RST,   4'b0011, "nom_hbm_rel");
    pushExpect(b + 53,  F_STATE, 2,       "nom_cal_wait");
    pushExpect(b + 302, F_STATE, 2,       "nom_pre_noc");
    pushExpect(b + 303, F_RST,   4'b0001, "nom_noc_rel");
    pushExpect(b + 334, F_RST,   4'b0001, "nom_pre_axi");
    pushExpect(b + 334, F_READY, 0,       "nom_pre_ready");
    pushExpect(b + 335, F_RST,   4'b0000, "nom_axi_rel");
    pushExpect(b + 335, F_READY, 1,       "nom_ready");
    pushExpect(b + 335, F_STATE, 4,       "nom_run");
    pushExpect(b + 335, F_RETRY, 0,       "nom_retry");
    applyStimulus(b + 50,  S_LOCK,  1);
    applyStimulus(b + 300, S_CALOK, 1);
    drain(200);

    // Cal retry: lock already present, cal_fail on first attempt, success on second
    calOk = 1'b0;
    resetDut("calr", b);
    pushExpect(b + 17, F_STATE, 2,       "calr_cal_wait1");
    pushExpect(b + 17, F_RST,   4'b0011, "calr_rst1");
    pushExpect(b + 32, F_STATE, 2,       "calr_pre_retry");
    pushExpect(b + 33, F_STATE, 5,       "calr_retry");
    pushExpect(b + 33, F_RST,   4'b1111, "calr_retry_rst");
    pushExpect(b + 33, F_RETRY, 1,       "calr_retry_cnt");
    pushExpect(b + 34, F_STATE, 0,       "calr_hold2");
    pushExpect(b + 34, F_RETRY, 1,       "calr_hold2_cnt");
    pushExpect(b + 49, F_RST,   4'b1111, "calr_hold2_rst");
    pushExpect(b + 50, F_RST,   4'b0111, "calr_iopll2");
    pushExpect(b + 51, F_RST,   4'b0011, "calr_hbm2");
    pushExpect(b + 63, F_RST,   4'b0001, "calr_noc2");
    pushExpect(b + 94, F_RETRY, 1,       "calr_pre_run_cnt");
    pushExpect(b + 95, F_RST,   4'b0000, "calr_axi2");
    pushExpect(b + 95, F_READY, 1,       "calr_ready");
    pushExpect(b + 95, F_RETRY, 0,       "calr_run_clear");
    applyStimulus(b + 30, S_CALFAIL, 1);
    applyStimulus(b + 32, S_CALFAIL, 0);
    applyStimulus(b + 60, S_CALOK,   1);
    drain(200);

    // Lock loss while running
    pushExpect(b + 122, F_READY, 1,       "lost_pre");
    pushExpect(b + 123, F_READY, 0,       "lost_ready");
    pushExpect(b + 123, F_RST,   4'b1111, "lost_rst");
    pushExpect(b + 123, F_RETRY, 1,       "lost_retry");
    pushExpect(b + 123, F_STATE, 5,       "lost_state");
    applyStimulus(b + 120, S_LOCK, 0);
    drain(100);

    // Retry exhaustion: lock never comes
    calOk = 1'b0;
    resetDut("exh", b);
    pushExpect(b + 1015, F_STATE, 1,       "exh_pll1");
    pushExpect(b + 1016, F_STATE, 5,       "exh_to1");
    pushExpect(b + 1016, F_RETRY, 1,       "exh_cnt1");
    pushExpect(b + 1017, F_STATE, 0,       "exh_hold2");
    pushExpect(b + 2033, F_RETRY, 2,       "exh_cnt2");
    pushExpect(b + 3050, F_STATE, 5,       "exh_to3");
    pushExpect(b + 3050, F_RETRY, 3,       "exh_cnt3");
    pushExpect(b + 3051, F_STATE, 6,       "exh_fail_state");
    pushExpect(b + 3051, F_FAIL,  1,       "exh_fail");
    pushExpect(b + 3051, F_RST,   4'b1111, "exh_fail_rst");
    pushExpect(b + 3060, F_STATE, 6,       "exh_fail_hold");
    pushExpect(b + 3071, F_STATE, 0,       "exh_restart_state");
    pushExpect(b + 3071, F_RETRY, 0,       "exh_restart_cnt");
    pushExpect(b + 3071, F_FAIL,  0,       "exh_restart_fail");
    applyStimulus(b + 3070, S_RESTART, 1);
    applyStimulus(b + 3071, S_RESTART, 0);
    drain(200);

    // Cattrip seen by the FSM in the same cycle as restart_req, during CAL_WAIT
    lockIn = 1'b1;
    resetDut("trip", b);
    pushExpect(b + 42, F_STATE, 2,       "trip_pre");
    pushExpect(b + 43, F_STATE, 7,       "trip_state");
    pushExpect(b + 43, F_TRIP,  1,       "trip_flag");
    pushExpect(b + 43, F_RST,   4'b1111, "trip_rst");
    pushExpect(b + 61, F_STATE, 7,       "trip_restart_ignored");
    pushExpect(b + 70, F_TRIP,  1,       "trip_sticky");
    applyStimulus(b + 40, S_CATTRIP, 1);
    applyStimulus(b + 42, S_RESTART, 1);
    applyStimulus(b + 43, S_RESTART, 0);
    applyStimulus(b + 50, S_CATTRIP, 0);
    applyStimulus(b + 60, S_RESTART, 1);
    applyStimulus(b + 61, S_RESTART, 0);
    drain(100);

    // Temperature warning 4 -> 5 -> 4, thermal flag cleared by reset
    lockIn = 1'b0;
    resetDut("temp", b);
    pushExpect(b + 10, F_WARN,  0, "temp_four");
    pushExpect(b + 22, F_WARN,  0, "temp_pre_rise");
    pushExpect(b + 23, F_WARN,  1, "temp_rise");
    pushExpect(b + 42, F_WARN,  1, "temp_pre_fall");
    pushExpect(b + 43, F_WARN,  0, "temp_fall");
    pushExpect(b + 43, F_STATE, 1, "temp_no_state_effect");
    applyStimulus(b + 5,  S_TEMP, 4);
    applyStimulus(b + 20, S_TEMP, 5);
    applyStimulus(b + 40, S_TEMP, 4);
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
